// File: rtl/vga_arb_pkg.sv
// Shared widths, default screen limits and arbiter state encoding for the VGA plot arbiter.
package vga_arb_pkg;

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;

    localparam int unsigned X_MAX_DEF = 160;
    localparam int unsigned Y_MAX_DEF = 120;

    typedef enum logic [0:0] {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic        found;
    int unsigned j;

    // Scan requesters starting at ptr; the first valid one wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && valid[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter write port between drawing engines: round-robin grant with optional
// burst lock, one registered pixel per cycle, off-screen pixels dropped and counted.
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned X_MAX = X_MAX_DEF,
    parameter int unsigned Y_MAX = Y_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*XW-1:0] req_x,
    input  logic [NREQ*YW-1:0] req_y,
    input  logic [NREQ*CW-1:0] req_colour,
    output logic [NREQ-1:0]    req_ready,
    output logic [XW-1:0]      vga_x,
    output logic [YW-1:0]      vga_y,
    output logic [CW-1:0]      vga_colour,
    output logic               vga_plot,
    output logic [15:0]        clip_count,
    output logic               busy
);

    localparam int unsigned PW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   owner_q, owner_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   gidx;
    logic [NREQ-1:0] ready;
    logic            xfer;

    logic [XW-1:0]   sel_x;
    logic [YW-1:0]   sel_y;
    logic [CW-1:0]   sel_c;
    logic            in_bounds;

    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   c_q;
    logic            plot_q;
    logic [15:0]     clip_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (32'(i) == NREQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    // Grant: round-robin when free, owner only when locked; nothing is granted during reset.
    always_comb begin
        ready = '0;
        gidx  = pick_idx;
        if (state_q == LOCKED) begin
            gidx = owner_q;
            if (req_valid[owner_q]) begin
                ready[owner_q] = 1'b1;
            end
        end else begin
            ready = pick_gnt;
        end
        if (!rst_n) begin
            ready = '0;
        end
    end

    assign req_ready = ready;
    assign xfer      = |(req_valid & ready);

    // Select the granted requester's pixel slice and bounds-check it at full port width.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gidx == PW'(i)) begin
                sel_x = req_x[i*XW +: XW];
                sel_y = req_y[i*YW +: YW];
                sel_c = req_colour[i*CW +: CW];
            end
        end
        in_bounds = (32'(sel_x) < X_MAX) && (32'(sel_y) < Y_MAX);
    end

    // Lock FSM next state; rr is frozen while locked and resumes after the owner.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        unique case (state_q)
            FREE: begin
                if (xfer) begin
                    rr_d = wrap_inc(gidx);
                    if (req_lock[gidx]) begin
                        owner_d = gidx;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!req_lock[owner_q]) begin
                    state_d = FREE;
                    rr_d    = wrap_inc(owner_q);
                end
            end
            default: state_d = FREE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FREE;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // Output stage: register in-bounds pixels, count and drop the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            c_q    <= '0;
            plot_q <= 1'b0;
            clip_q <= '0;
        end else begin
            plot_q <= xfer & in_bounds;
            if (xfer && in_bounds) begin
                x_q <= sel_x;
                y_q <= sel_y;
                c_q <= sel_c;
            end
            if (xfer && !in_bounds && (clip_q != 16'hFFFF)) begin
                clip_q <= clip_q + 16'd1;
            end
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = c_q;
    assign vga_plot   = plot_q;
    assign clip_count = clip_q;
    assign busy       = (state_q == LOCKED) | plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Table-driven bench for vga_plot_arbiter (NREQ=3, 160x120) plus reset and saturation sequences.
module tb_vga_plot_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_lock;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  req_ready;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [15:0] clip_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    vga_plot_arbiter #(
        .NREQ  (3),
        .X_MAX (160),
        .Y_MAX (120)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .clip_count (clip_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester i presents (bx+i, by+i, bc+i), wrapping at port width.
    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  lock;
        logic [7:0]  bx;
        logic [6:0]  by;
        logic [2:0]  bc;
        logic [2:0]  e_ready;
        logic        e_plot;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_c;
        logic [15:0] e_clip;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] valid, logic [2:0] lock, logic [7:0] bx,
                                logic [6:0] by, logic [2:0] bc, logic [2:0] e_ready,
                                logic e_plot, logic [7:0] e_x, logic [6:0] e_y,
                                logic [2:0] e_c, logic [15:0] e_clip, logic e_busy);
        vec_t v;
        v.valid = valid;  v.lock = lock;
        v.bx = bx;  v.by = by;  v.bc = bc;
        v.e_ready = e_ready;  v.e_plot = e_plot;
        v.e_x = e_x;  v.e_y = e_y;  v.e_c = e_c;
        v.e_clip = e_clip;  v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input logic [2:0] valid, input logic [2:0] lock, input logic [7:0] bx,
                         input logic [6:0] by, input logic [2:0] bc);
        req_valid = valid;
        req_lock  = lock;
        for (int i = 0; i < 3; i++) begin
            req_x[i*8 +: 8]      = bx + 8'(i);
            req_y[i*7 +: 7]      = by + 7'(i);
            req_colour[i*3 +: 3] = bc + 3'(i);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic plot, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] c, input logic [15:0] clip,
                            input logic bsy);
        chk({tag, " vga_plot"},   32'(vga_plot),   32'(plot));
        chk({tag, " vga_x"},      32'(vga_x),      32'(x));
        chk({tag, " vga_y"},      32'(vga_y),      32'(y));
        chk({tag, " vga_colour"}, 32'(vga_colour), 32'(c));
        chk({tag, " clip_count"}, 32'(clip_count), 32'(clip));
        chk({tag, " busy"},       32'(busy),       32'(bsy));
    endtask

    initial begin
        // Single requester
        vecs.push_back(mk(3'b010, 3'b000,   9, 19, 3'd4, 3'b010, 1,  10,  20, 3'd5, 0, 1));
        // Fairness, rr starts at 2
        vecs.push_back(mk(3'b111, 3'b000,  40, 50, 3'd0, 3'b100, 1,  42,  52, 3'd2, 0, 1));
        vecs.push_back(mk(3'b111, 3'b000,  40, 50, 3'd0, 3'b001, 1,  40,  50, 3'd0, 0, 1));
        vecs.push_back(mk(3'b111, 3'b000,  40, 50, 3'd0, 3'b010, 1,  41,  51, 3'd1, 0, 1));
        vecs.push_back(mk(3'b111, 3'b000,  40, 50, 3'd0, 3'b100, 1,  42,  52, 3'd2, 0, 1));
        vecs.push_back(mk(3'b111, 3'b000,  40, 50, 3'd0, 3'b001, 1,  40,  50, 3'd0, 0, 1));
        // Idle holds coordinates
        vecs.push_back(mk(3'b000, 3'b000,  40, 50, 3'd0, 3'b000, 0,  40,  50, 3'd0, 0, 0));
        // Lock from an ungranted requester is ignored
        vecs.push_back(mk(3'b111, 3'b100,  40, 50, 3'd0, 3'b010, 1,  41,  51, 3'd1, 0, 1));
        // Req 2 lock burst
        vecs.push_back(mk(3'b111, 3'b100,  60, 70, 3'd4, 3'b100, 1,  62,  72, 3'd6, 0, 1));
        vecs.push_back(mk(3'b111, 3'b100,  80, 90, 3'd0, 3'b100, 1,  82,  92, 3'd2, 0, 1));
        // Owner idles while locked: nobody else granted
        vecs.push_back(mk(3'b011, 3'b100,  80, 90, 3'd0, 3'b000, 0,  82,  92, 3'd2, 0, 1));
        vecs.push_back(mk(3'b111, 3'b100, 100, 10, 3'd1, 3'b100, 1, 102,  12, 3'd3, 0, 1));
        vecs.push_back(mk(3'b111, 3'b100,   3,  4, 3'd5, 3'b100, 1,   5,   6, 3'd7, 0, 1));
        // Lock dropped on the fifth transfer, still accepted
        vecs.push_back(mk(3'b111, 3'b000, 110, 20, 3'd2, 3'b100, 1, 112,  22, 3'd4, 0, 1));
        vecs.push_back(mk(3'b111, 3'b000,   1,  2, 3'd3, 3'b001, 1,   1,   2, 3'd3, 0, 1));
        // Clipping on req 0
        vecs.push_back(mk(3'b001, 3'b000, 160,   0, 3'd1, 3'b001, 0,  1,   2, 3'd3, 1, 0));
        vecs.push_back(mk(3'b001, 3'b000,   0, 120, 3'd1, 3'b001, 0,  1,   2, 3'd3, 2, 0));
        vecs.push_back(mk(3'b001, 3'b000, 255, 127, 3'd7, 3'b001, 0,  1,   2, 3'd3, 3, 0));
        vecs.push_back(mk(3'b001, 3'b000, 159, 119, 3'd6, 3'b001, 1, 159, 119, 3'd6, 3, 1));
        vecs.push_back(mk(3'b001, 3'b000, 200,   5, 3'd1, 3'b001, 0, 159, 119, 3'd6, 4, 0));

        // Reset state, with requests pending
        rst_n = 1'b0;
        drive(3'b111, 3'b111, 8'd0, 7'd0, 3'd0);
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk_outs("reset", 0, 8'd0, 7'd0, 3'd0, 16'd0, 0);
        drive(3'b000, 3'b000, 8'd0, 7'd0, 3'd0);
        rst_n = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            drive(vecs[n].valid, vecs[n].lock, vecs[n].bx, vecs[n].by, vecs[n].bc);
            #1;
            chk($sformatf("vec%0d req_ready", n), 32'(req_ready), 32'(vecs[n].e_ready));
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", n), vecs[n].e_plot, vecs[n].e_x, vecs[n].e_y,
                     vecs[n].e_c, vecs[n].e_clip, vecs[n].e_busy);
        end

        // Reset mid-lock: rr is 1 here, req 1 grabs the lock
        @(negedge clk);
        drive(3'b111, 3'b010, 8'd5, 7'd6, 3'd0);
        #1;
        chk("lock grab req_ready", 32'(req_ready), 32'b010);
        @(negedge clk);
        #1;
        chk("locked req_ready", 32'(req_ready), 32'b010);
        chk_outs("locked", 1, 8'd6, 7'd7, 3'd1, 16'd4, 1);
        rst_n = 1'b0;
        #1;
        chk("midlock reset req_ready", 32'(req_ready), 32'd0);
        chk_outs("midlock reset", 0, 8'd0, 7'd0, 3'd0, 16'd0, 0);
        @(negedge clk);
        drive(3'b111, 3'b000, 8'd5, 7'd6, 3'd0);
        rst_n = 1'b1;
        #1;
        chk("post reset req_ready", 32'(req_ready), 32'b001);
        chk("post reset vga_plot", 32'(vga_plot), 32'd0);
        @(posedge clk);
        #1;
        chk_outs("post reset", 1, 8'd5, 7'd6, 3'd0, 16'd0, 1);

        // Saturation: 65540 clipped pixels from req 0
        @(negedge clk);
        drive(3'b001, 3'b000, 8'd200, 7'd5, 3'd1);
        for (int k = 1; k <= 65540; k++) begin
            @(posedge clk);
            #1;
            if (k == 65534) begin
                chk("sat pre clip_count", 32'(clip_count), 32'hFFFE);
            end
        end
        chk("sat clip_count", 32'(clip_count), 32'hFFFF);
        chk("sat vga_plot", 32'(vga_plot), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
